// File: rtl/lcd_framebuffer_axi3_dma_writer.sv
// Packs an RGB565 pixel stream into 32-bit words and writes a frame as fixed 16-beat AXI3 INCR bursts.
// Latency: awvalid follows the FIFO reaching 16 words by one cycle; backpressure stalls pixels only when the FIFO is full.

module dma_wr_fifo #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [AW:0]   cnt_o,
  output logic          full_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Show-ahead: the head word is visible without a read strobe.
  assign head_dat_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
endmodule

module lcd_framebuffer_axi3_dma_writer #(
  parameter int FRAME_BURSTS    = 4080,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] START_ADDRESS,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  input  logic [15:0] PIXEL_DATA,
  input  logic        PIXEL_VALID,
  output logic        PIXEL_READY,
  output logic [31:0] m00_axi_awaddr,
  output logic [3:0]  m00_axi_awlen,
  output logic [2:0]  m00_axi_awsize,
  output logic [1:0]  m00_axi_awburst,
  output logic        m00_axi_awvalid,
  input  logic        m00_axi_awready,
  output logic [31:0] m00_axi_wdata,
  output logic [3:0]  m00_axi_wstrb,
  output logic        m00_axi_wlast,
  output logic        m00_axi_wvalid,
  input  logic        m00_axi_wready,
  input  logic [1:0]  m00_axi_bresp,
  input  logic        m00_axi_bvalid,
  output logic        m00_axi_bready
);
  localparam int          CW        = FIFO_DEPTH_LOG2 + 1;
  localparam logic [31:0] PIX_TOTAL = 32'(FRAME_BURSTS) << 5;

  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        odd_q, odd_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic          pix_acc, fifo_push, fifo_pop, fifo_full;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_cnt;

  dma_wr_fifo #(.W(32), .AW(FIFO_DEPTH_LOG2)) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push_i     (fifo_push),
    .push_dat_i ({PIXEL_DATA, hold_q}),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .cnt_o      (fifo_cnt),
    .full_o     (fifo_full)
  );

  assign BUSY        = (state_q != IDLE);
  assign PIXEL_READY = BUSY & ~fifo_full & (pix_cnt_q < PIX_TOTAL);
  assign pix_acc     = PIXEL_VALID & PIXEL_READY;
  assign fifo_push   = pix_acc & odd_q;
  assign fifo_pop    = (state_q == DATA) & m00_axi_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    pix_cnt_d = pix_cnt_q;
    hold_d    = hold_q;
    odd_d     = odd_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (pix_acc) begin
      pix_cnt_d = pix_cnt_q + 32'd1;
      odd_d     = ~odd_q;
      if (!odd_q) hold_d = PIXEL_DATA;
    end

    case (state_q)
      IDLE: if (START) begin
        state_d   = WAIT_DATA;
        addr_d    = START_ADDRESS;
        err_d     = 1'b0;
        burst_d   = '0;
        beat_d    = '0;
        pix_cnt_d = '0;
        odd_d     = 1'b0;
        hold_d    = '0;
      end
      WAIT_DATA: if (fifo_cnt >= CW'(16)) state_d = ADDR;
      ADDR:      if (m00_axi_awready) state_d = DATA;
      DATA: if (m00_axi_wready) begin
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'd15) state_d = RESP;
      end
      RESP: if (m00_axi_bvalid) begin
        if (m00_axi_bresp != 2'b00) err_d = 1'b1;
        addr_d  = addr_q + 32'd64;
        burst_d = burst_q + 32'd1;
        if (burst_q + 32'd1 == 32'(FRAME_BURSTS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      pix_cnt_q <= '0;
      hold_q    <= '0;
      odd_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      pix_cnt_q <= pix_cnt_d;
      hold_q    <= hold_d;
      odd_q     <= odd_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign DONE            = done_q;
  assign ERROR           = err_q;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awlen   = 4'hF;
  assign m00_axi_awsize  = 3'b010;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awvalid = (state_q == ADDR);
  assign m00_axi_wdata   = fifo_head;
  assign m00_axi_wstrb   = 4'hF;
  assign m00_axi_wvalid  = (state_q == DATA);
  assign m00_axi_wlast   = (state_q == DATA) && (beat_q == 4'd15);
  assign m00_axi_bready  = (state_q == RESP);
endmodule

// File: tb/tb_lcd_framebuffer_axi3_dma_writer.sv
// Scoreboard bench for the framebuffer DMA writer: stimulus pushes expected AW addresses and W words,
// an AXI slave model answers with programmable stalls, and a negedge monitor compares every handshake.
module tb_lcd_framebuffer_axi3_dma_writer;
  logic        CLK = 1'b0;
  logic        RESET, START, PIXEL_VALID, PIXEL_READY, BUSY, DONE, ERROR;
  logic [31:0] START_ADDRESS;
  logic [15:0] PIXEL_DATA;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awlen, wstrb;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  lcd_framebuffer_axi3_dma_writer #(.FRAME_BURSTS(3), .FIFO_DEPTH_LOG2(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_ADDRESS(START_ADDRESS),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .PIXEL_DATA(PIXEL_DATA), .PIXEL_VALID(PIXEL_VALID), .PIXEL_READY(PIXEL_READY),
    .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
    .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  int  w_in_frame = 0, frame_b = 0, b_count = 0, done_count = 0, done_target = 0, pix_acc = 0;
  bit  err_model = 0, err_chk_next = 0, exp_done_next = 0;
  int  aw_delay = 0, b_delay = 0, err_at = -1, aw_wait = 0, b_wait = 0;
  bit  w_toggle = 0, aw_hold = 0;
  logic [15:0] pix_next = 16'd0;
  bit  pw_stall = 0, paw_stall = 0, pw_last = 0;
  logic [31:0] pw_dat = '0, paw_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(BUSY), 0);          check("rst_done", 32'(DONE), 0);
    check("rst_error", 32'(ERROR), 0);        check("rst_pixel_ready", 32'(PIXEL_READY), 0);
    check("rst_awvalid", 32'(awvalid), 0);    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_wlast", 32'(wlast), 0);        check("rst_bready", 32'(bready), 0);
    check("rst_awaddr", awaddr, 32'h0);
  endtask

  task automatic check_queues();
    check("aw_queue_drained", 32'(exp_aw.size()), 0);
    check("w_queue_drained", 32'(exp_w.size()), 0);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic start_frame(input logic [31:0] a);
    START = 1'b1; START_ADDRESS = a;
    exp_aw.push_back(a); exp_aw.push_back(a + 32'd64); exp_aw.push_back(a + 32'd128);
    err_model = 0; frame_b = 0; w_in_frame = 0; done_target = done_count + 1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("start_busy", 32'(BUSY), 1);
    check("start_clears_error", 32'(ERROR), 0);
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] prev, v;
    int t;
    prev = '0;
    for (int i = 0; i < n; i++) begin
      v = pix_next; pix_next = pix_next + 16'd1;
      if (i % 2 == 1) exp_w.push_back({v, prev});
      else prev = v;
      PIXEL_DATA = v; PIXEL_VALID = 1'b1;
      t = 0;
      @(negedge CLK);
      while (!PIXEL_READY && t < 2000) begin t++; @(negedge CLK); end
      if (t >= 2000) begin
        $display("FAIL pixel_timeout: pixel %0d never accepted", i);
        n_checks++;
        PIXEL_VALID = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    PIXEL_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_count < done_target && t < 3000) begin @(posedge CLK); #1; t++; end
    if (t >= 3000) $display("FAIL done_timeout: done_count %0d, expected %0d", done_count, done_target);
    n_checks++;
    if (t < 3000) n_pass++;
  endtask

  // AXI slave model
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(posedge CLK); #1;
      aw_wait = awvalid ? aw_wait + 1 : 0;
      awready = awvalid && (aw_wait > aw_delay) && !aw_hold;
      wready  = w_toggle ? ~wready : 1'b1;
      b_wait  = bready ? b_wait + 1 : 0;
      bvalid  = bready && (b_wait > b_delay);
      bresp   = (b_count == err_at) ? 2'b10 : 2'b00;
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (RESET) begin
      pw_stall = 0; paw_stall = 0;
    end else begin
      if (pw_stall) begin
        check("w_stable_valid", 32'(wvalid), 1);
        check("w_stable_data", wdata, pw_dat);
        check("w_stable_last", 32'(wlast), 32'(pw_last));
      end
      if (paw_stall) begin
        check("aw_stable_valid", 32'(awvalid), 1);
        check("aw_stable_addr", awaddr, paw_addr);
      end
      if (exp_done_next) begin
        check("done_pulse", 32'(DONE), 1);
        check("done_busy_clear", 32'(BUSY), 0);
        check("done_error", 32'(ERROR), 32'(err_model));
        exp_done_next = 0;
      end else if (DONE) fail_now("done_spurious");
      if (DONE) done_count++;
      if (err_chk_next) begin check("error_set", 32'(ERROR), 1); err_chk_next = 0; end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          check("awaddr", awaddr, exp_aw.pop_front());
          check("awlen_size_burst", {21'd0, awlen, awsize, awburst, wstrb}, {21'd0, 4'hF, 3'b010, 2'b01, 4'hF});
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          check("wdata", wdata, exp_w.pop_front());
          check("wlast", 32'(wlast), 32'(w_in_frame % 16 == 15));
        end
        w_in_frame++;
      end
      if (bvalid && bready) begin
        b_count++; frame_b++;
        if (bresp != 2'b00) begin err_model = 1; err_chk_next = 1; end
        if (frame_b == 3) exp_done_next = 1;
      end
      if (PIXEL_VALID && PIXEL_READY) pix_acc++;
      pw_stall = wvalid && !wready; pw_dat = wdata; pw_last = wlast;
      paw_stall = awvalid && !awready; paw_addr = awaddr;
    end
  end

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1; START = 0; START_ADDRESS = '0; PIXEL_DATA = '0; PIXEL_VALID = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals();
    @(posedge CLK); #1 RESET = 0;

    // Back-to-back frame, slave always ready
    start_frame(32'h8000_0000);
    send_pixels(96);
    wait_done();
    @(negedge CLK); check("idle_busy", 32'(BUSY), 0);
    check_queues();
    @(posedge CLK); #1;

    // Stalling slave plus an ignored mid-frame START
    aw_delay = 5; w_toggle = 1; b_delay = 3;
    start_frame(32'h8000_0000);
    fork
      send_pixels(96);
      begin
        repeat (60) @(posedge CLK);
        #1 START = 1; START_ADDRESS = 32'h1234_0000;
        @(posedge CLK); #1 START = 0;
      end
    join
    wait_done();
    check_queues();
    PIXEL_VALID = 1;
    for (int i = 0; i < 3; i++) begin @(negedge CLK); check("ready_after_done", 32'(PIXEL_READY), 0); end
    @(posedge CLK); #1 PIXEL_VALID = 0;

    // Address channel held off: FIFO fills to 64 pixels then backpressures
    aw_delay = 0; w_toggle = 0; b_delay = 0; aw_hold = 1;
    start_frame(32'h8000_0000);
    pix_acc = 0;
    fork
      send_pixels(96);
      begin
        repeat (200) @(posedge CLK);
        @(negedge CLK);
        check("accepted_while_held", 32'(pix_acc), 64);
        check("ready_while_held", 32'(PIXEL_READY), 0);
        @(posedge CLK); #1 aw_hold = 0;
      end
    join
    wait_done();
    check("accepted_total", 32'(pix_acc), 96);
    check_queues();

    // SLVERR on the second burst only
    err_at = b_count + 1;
    start_frame(32'h4000_0000);
    send_pixels(96);
    wait_done();
    @(negedge CLK); check("error_sticky_after_done", 32'(ERROR), 1);
    check_queues();
    err_at = -1;
    @(posedge CLK); #1;

    // Reset in the middle of burst 1 with an unpaired pixel in the packer
    start_frame(32'h0000_2000);
    fork
      send_pixels(33);
      begin
        int t = 0;
        while (w_in_frame < 7 && t < 2000) begin @(negedge CLK); t++; end
        check("reached_beat7", 32'(w_in_frame >= 7), 1);
        @(posedge CLK); #1;
        RESET = 1;
      end
    join
    exp_aw.delete(); exp_w.delete();
    @(posedge CLK); @(negedge CLK);
    check_reset_vals();
    @(posedge CLK); #1;
    RESET = 0; w_in_frame = 0; frame_b = 0; exp_done_next = 0;
    start_frame(32'h0000_1000);
    send_pixels(96);
    wait_done();
    check_queues();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
